pwm_duty_sequencer: RTL and testbench
=====================================

# pwm_duty_sequencer

Controller that sequences the six-level PWM stage of the anti-pinch board (levels 0%, 5%, 10%, 25%, 50%, 100%, selected by a 3-bit index). It takes the debounced key press and the anti-pinch alarm and decides which duty level the PWM uses and whether the PWM is enabled. Supported behaviours are manual stepping, an automatic breathing ramp, and an alarm blink that pre-empts both. It sits between the key debouncer / pinch detector and the PWM generator.

## Interface
- STEP_CYCLES, 20_000_000, SYSCLK cycles per breathing step (200 ms at 100 MHz); must be ≥ 2.
- ALARM_CYCLES, 25_000_000, SYSCLK cycles per alarm blink half-period; must be ≥ 2.
- SYSCLK  in  1  system clock, 100 MHz; all logic is on the rising edge.
- RST  in  1  reset; synchronous and active-high.
- key_pulse  in  1  one-cycle pulse per debounced key press.
- pinch_alarm  in  1  level signal; high while a pinch is detected. It is synchronous to SYSCLK.
- alarm_ack  in  1  one-cycle operator acknowledge pulse.
- duty_sel  out  3  PWM level index, 0..5. Values 6 and 7 are never driven.
- pwm_en  out  1  PWM output enable.
- mode  out  2  current state: OFF=0, MANUAL=1, BREATH=2, ALARM=3.
- alarm_active  out  1  high while in ALARM.

## Operation
- All outputs are registered.
- Reset values: state OFF, duty_sel 0, pwm_en 0, mode 0, alarm_active 0.
- Reset also clears the step counter and the blink counter, sets dir to up, and clears the saved context.
- The FSM has four states. Transitions are listed in priority order; the ALARM entry rule comes first.
  - Any state except ALARM, with pinch_alarm=1: go to ALARM.
    - Save the current state, duty_sel and dir.
    - Set duty_sel to 5 and clear the blink counter.
    - Drop a key_pulse that arrives in the same cycle.
  - OFF:
    - duty_sel=0 and pwm_en=0.
    - key_pulse: go to MANUAL with duty_sel=1.
  - MANUAL:
    - pwm_en=1.
    - key_pulse with duty_sel<5: increment duty_sel.
    - key_pulse with duty_sel=5: go to BREATH. duty_sel stays 5, dir is set to down, and the step counter is cleared.
  - BREATH:
    - pwm_en=1.
    - When the step counter reaches STEP_CYCLES-1 it wraps to 0 and duty_sel moves one level in the direction dir.
    - The ramp is a triangle wave: 5,4,3,2,1,0,1,2,…,5,4,… Endpoint values are not repeated; dir flips on the same step that lands on 0 or 5.
    - key_pulse: go to OFF, with duty_sel=0 and pwm_en=0.
  - ALARM:
    - pwm_en=1 and alarm_active=1.
    - The blink counter wraps every ALARM_CYCLES cycles. On each wrap duty_sel toggles between 5 and 0.
    - key_pulse is ignored.
    - Exit occurs only in a cycle where alarm_ack=1 and pinch_alarm=0.
      - On exit, restore the saved state, duty_sel and dir, and clear the step counter.
      - If the saved state is OFF, the restored values are duty_sel=0 and pwm_en=0.
    - alarm_ack while pinch_alarm=1 is discarded and not latched.
- Counter widths: $clog2(STEP_CYCLES) and $clog2(ALARM_CYCLES). Both counters are unsigned and compare with ==.
- The step counter runs only in BREATH. The blink counter runs only in ALARM.

## Timing
- Each input sampled at edge n produces its output change visible after edge n, i.e. one cycle of latency. There is no combinational input-to-output path.
- After entering BREATH, the first ramp step occurs exactly STEP_CYCLES cycles after the entry edge. The same holds after restoring into BREATH from ALARM.
- After entering ALARM, duty_sel=5 holds for ALARM_CYCLES cycles, then 0 for ALARM_CYCLES cycles, and repeats.
- If pinch_alarm is still high after exit, ALARM is re-entered on the next edge. This is legal.
- RST has priority over every event. Asserting it mid-ramp or mid-alarm gives the reset values on the next edge, and the saved context is lost.

## Test plan
Every scenario runs with STEP_CYCLES=4 and ALARM_CYCLES=3.
- **Reset / manual stepping.** Assert RST, release it, then send 5 key_pulses.
  - mode goes 0→1, and duty_sel goes 0→1,2,3,4,5.
  - pwm_en=1 from the first press onwards.
- **Enter BREATH.** Send a 6th key_pulse.
  - mode=2 and duty_sel stays 5.
  - duty_sel then changes every 4 cycles: 4,3,2,1,0,1,2,3,4,5,4.
- **BREATH → OFF.** Send key_pulse during BREATH.
  - Next cycle: mode=0, duty_sel=0, pwm_en=0.
- **Alarm override.** From BREATH at duty_sel=2 with dir down, raise pinch_alarm.
  - mode=3 and alarm_active=1.
  - duty_sel runs 5,5,5,0,0,0,5…
  - Pulse alarm_ack while pinch_alarm=1: no change.
  - Drop pinch_alarm and pulse alarm_ack: mode=2 and duty_sel=2. The next step, 4 cycles later, gives duty_sel=1.
- **Simultaneous events.** Drive key_pulse and pinch_alarm high in the same cycle while in MANUAL at duty_sel=3.
  - Result is ALARM, and the saved duty_sel is 3 (not 4).
  - After ack, the block is in MANUAL with duty_sel=3.
- **Reset mid-alarm.** Assert RST during ALARM.
  - All outputs return to their reset values.
  - A later alarm_ack has no effect.

Source files
------------

// File: rtl/pwm_duty_sequencer.sv
// Duty-level sequencer for the anti-pinch PWM stage: manual stepping, a
// triangle breathing ramp, and an alarm blink that pre-empts both.
module pwm_duty_sequencer #(
  parameter int STEP_CYCLES  = 20_000_000,
  parameter int ALARM_CYCLES = 25_000_000
) (
  input  logic       SYSCLK,
  input  logic       RST,
  input  logic       key_pulse,
  input  logic       pinch_alarm,
  input  logic       alarm_ack,
  output logic [2:0] duty_sel,
  output logic       pwm_en,
  output logic [1:0] mode,
  output logic       alarm_active
);

  localparam int SW = $clog2(STEP_CYCLES);
  localparam int AW = $clog2(ALARM_CYCLES);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_CYCLES - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_MANUAL = 2'd1,
    S_BREATH = 2'd2,
    S_ALARM  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  state_t        savedState_q, savedState_d;
  logic [2:0]    duty_q, duty_d;
  logic [2:0]    savedDuty_q, savedDuty_d;
  logic          dirUp_q, dirUp_d;
  logic          savedDirUp_q, savedDirUp_d;
  logic          pwmEn_q, pwmEn_d;
  logic          alarm_q, alarm_d;
  logic [SW-1:0] stepCnt_q, stepCnt_d;
  logic [AW-1:0] blinkCnt_q, blinkCnt_d;

  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state_q      <= S_OFF;
      savedState_q <= S_OFF;
      duty_q       <= 3'd0;
      savedDuty_q  <= 3'd0;
      dirUp_q      <= 1'b1;
      savedDirUp_q <= 1'b1;
      pwmEn_q      <= 1'b0;
      alarm_q      <= 1'b0;
      stepCnt_q    <= '0;
      blinkCnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      savedState_q <= savedState_d;
      duty_q       <= duty_d;
      savedDuty_q  <= savedDuty_d;
      dirUp_q      <= dirUp_d;
      savedDirUp_q <= savedDirUp_d;
      pwmEn_q      <= pwmEn_d;
      alarm_q      <= alarm_d;
      stepCnt_q    <= stepCnt_d;
      blinkCnt_q   <= blinkCnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    savedState_d = savedState_q;
    duty_d       = duty_q;
    savedDuty_d  = savedDuty_q;
    dirUp_d      = dirUp_q;
    savedDirUp_d = savedDirUp_q;
    stepCnt_d    = stepCnt_q;
    blinkCnt_d   = blinkCnt_q;

    // Alarm entry outranks everything, including a same-cycle key press.
    if (state_q != S_ALARM && pinch_alarm) begin
      savedState_d = state_q;
      savedDuty_d  = duty_q;
      savedDirUp_d = dirUp_q;
      state_d      = S_ALARM;
      duty_d       = 3'd5;
      blinkCnt_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          duty_d = 3'd0;
          if (key_pulse) begin
            state_d = S_MANUAL;
            duty_d  = 3'd1;
          end
        end
        S_MANUAL: begin
          if (key_pulse) begin
            if (duty_q < 3'd5) begin
              duty_d = duty_q + 3'd1;
            end else begin
              state_d   = S_BREATH;
              dirUp_d   = 1'b0;
              stepCnt_d = '0;
            end
          end
        end
        S_BREATH: begin
          if (key_pulse) begin
            state_d = S_OFF;
            duty_d  = 3'd0;
          end else if (stepCnt_q == STEP_LAST) begin
            stepCnt_d = '0;
            // Direction flips on the step that lands on an endpoint.
            if (dirUp_q) begin
              duty_d = duty_q + 3'd1;
              if (duty_q == 3'd4) dirUp_d = 1'b0;
            end else begin
              duty_d = duty_q - 3'd1;
              if (duty_q == 3'd1) dirUp_d = 1'b1;
            end
          end else begin
            stepCnt_d = stepCnt_q + 1'b1;
          end
        end
        S_ALARM: begin
          if (alarm_ack && !pinch_alarm) begin
            state_d   = savedState_q;
            duty_d    = (savedState_q == S_OFF) ? 3'd0 : savedDuty_q;
            dirUp_d   = savedDirUp_q;
            stepCnt_d = '0;
          end else if (blinkCnt_q == ALARM_LAST) begin
            blinkCnt_d = '0;
            duty_d     = (duty_q == 3'd5) ? 3'd0 : 3'd5;
          end else begin
            blinkCnt_d = blinkCnt_q + 1'b1;
          end
        end
      endcase
    end

    pwmEn_d = (state_d != S_OFF);
    alarm_d = (state_d == S_ALARM);
  end

  assign duty_sel     = duty_q;
  assign pwm_en       = pwmEn_q;
  assign mode         = state_q;
  assign alarm_active = alarm_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench: directed scenarios plus random stimulus against a
// timestamp-based reference model of the duty sequencer.
module tb_pwm_duty_sequencer;

  localparam int STEP  = 4;
  localparam int ALARM = 3;

  logic       SYSCLK = 1'b0;
  logic       RST = 1'b1;
  logic       key_pulse = 1'b0;
  logic       pinch_alarm = 1'b0;
  logic       alarm_ack = 1'b0;
  logic [2:0] duty_sel;
  logic       pwm_en;
  logic [1:0] mode;
  logic       alarm_active;

  int vectors = 0;
  int miscompares = 0;

  // Model: breathing duty is derived from a phase and the entry cycle, the
  // blink from the alarm entry cycle; no counters are mirrored.
  int cyc = 0;
  int mState = 0;
  int mLevel = 0;
  int mPhase = 0;
  int mEntry = 0;
  int aEntry = 0;
  int sState = 0;
  int sLevel = 0;
  int sPhase = 0;

  pwm_duty_sequencer #(.STEP_CYCLES(STEP), .ALARM_CYCLES(ALARM)) dut (
    .SYSCLK(SYSCLK), .RST(RST), .key_pulse(key_pulse),
    .pinch_alarm(pinch_alarm), .alarm_ack(alarm_ack),
    .duty_sel(duty_sel), .pwm_en(pwm_en), .mode(mode),
    .alarm_active(alarm_active)
  );

  always #5 SYSCLK = ~SYSCLK;

  function automatic int triLevel(int k);
    int m;
    m = k % 10;
    return (m <= 5) ? 5 - m : m - 5;
  endfunction

  function automatic int breathPhase(int atCycle);
    return mPhase + (atCycle - mEntry) / STEP;
  endfunction

  function automatic int modelDuty();
    case (mState)
      1:       return mLevel;
      2:       return triLevel(breathPhase(cyc));
      3:       return (((cyc - aEntry) / ALARM) % 2 == 1) ? 0 : 5;
      default: return 0;
    endcase
  endfunction

  task automatic stepModel(input bit k, input bit p, input bit a, input bit r);
    cyc++;
    if (r) begin
      mState = 0; mLevel = 0; sState = 0; sLevel = 0; sPhase = 0;
    end else if (mState != 3 && p) begin
      sState = mState;
      sLevel = mLevel;
      sPhase = (mState == 2) ? breathPhase(cyc - 1) : 0;
      aEntry = cyc;
      mState = 3;
    end else begin
      case (mState)
        0: if (k) begin mState = 1; mLevel = 1; end
        1: if (k) begin
             if (mLevel < 5) mLevel++;
             else begin mState = 2; mPhase = 0; mEntry = cyc; end
           end
        2: if (k) mState = 0;
        default: if (a && !p) begin
             mState = sState;
             mLevel = sLevel;
             mPhase = sPhase;
             mEntry = cyc;
           end
      endcase
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit k, input bit p, input bit a, input bit r);
    key_pulse   = k;
    pinch_alarm = p;
    alarm_ack   = a;
    RST         = r;
    @(posedge SYSCLK);
    stepModel(k, p, a, r);
    #1;
    checkOutput("duty_sel", 32'(duty_sel), 32'(modelDuty()));
    checkOutput("pwm_en", 32'(pwm_en), 32'(mState != 0));
    checkOutput("mode", 32'(mode), 32'(mState));
    checkOutput("alarm_active", 32'(alarm_active), 32'(mState == 3));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  bit pRand;

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_duty", 32'(duty_sel), 32'd0);
    checkOutput("reset_pwm_en", 32'(pwm_en), 32'd0);

    // Manual stepping up to the top level, then into the breathing ramp.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      idle(1);
    end
    checkOutput("manual_top", 32'(duty_sel), 32'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("breath_entry_mode", 32'(mode), 32'd2);
    idle(4 * 11);
    checkOutput("breath_11_steps", 32'(duty_sel), 32'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("breath_off_mode", 32'(mode), 32'd0);

    // Reach BREATH at duty 2 heading down, then alarm override and restore.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      idle(1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle(12);
    checkOutput("breath_at_2", 32'(duty_sel), 32'd2);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("ack_with_pinch_mode", 32'(mode), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("restore_mode", 32'(mode), 32'd2);
    checkOutput("restore_duty", 32'(duty_sel), 32'd2);
    idle(4);
    checkOutput("restore_first_step", 32'(duty_sel), 32'd1);

    // Key press coinciding with alarm entry is dropped.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      idle(1);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("simul_alarm_mode", 32'(mode), 32'd3);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("simul_restore_mode", 32'(mode), 32'd1);
    checkOutput("simul_restore_duty", 32'(duty_sel), 32'd3);

    // Reset in the middle of an alarm discards the saved context.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_alarm_active", 32'(alarm_active), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("late_ack_mode", 32'(mode), 32'd0);

    pRand = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) pRand = ~pRand;
      applyStimulus($urandom_range(0, 5) == 0, pRand,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 599) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
